// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-port widths, word types and copy FSM states
package mem_pkg;

  localparam int MEM_AW     = 8;
  localparam int MEM_DW     = 16;
  localparam int MEM_RD_LAT = 1;

  typedef logic [MEM_AW-1:0] mem_addr_t;
  typedef logic [MEM_DW-1:0] mem_data_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FIN
  } copy_state_t;

endpackage

// File: rtl/mem_sync.sv
// rtl/mem_sync.sv - single-port synchronous memory, one-edge read latency
//   clk      : system clock
//   address  : word address
//   wd / wen : write data / write enable
//   rd       : registered read data for the address sampled on the previous edge
module mem_sync
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] wd,
  input  logic          wen,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[address] <= wd;
    end
    rd <= mem[address];
  end

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - forward word-by-word copy over a single memory port
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, only honoured in IDLE
//   src_addr, dst_addr  : first source / destination word
//   len                 : word count 0..2**AW
//   busy, done, count   : status (registered)
//   address, wd, wen    : memory request (registered)
//   rd                  : memory read data
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW,
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [AW-1:0] address,
  output logic [DW-1:0] wd,
  output logic          wen,
  input  logic [DW-1:0] rd
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  copy_state_t   state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      address  <= '0;
      wd       <= '0;
      wen      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      wait_cnt <= '0;
    end else begin
      // wen and done are single-cycle; only the transition into WR / FIN raises them.
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            count <= '0;
            if (len != '0) begin
              state   <= RD;
              busy    <= 1'b1;
              address <= src_addr;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == WCW'(RD_LAT - 1)) begin
            // wd doubles as the captured-word register, so the write
            // request is fully formed on the edge that leaves WAIT.
            state   <= WR;
            wd      <= rd;
            address <= dst_q + count[AW-1:0];
            wen     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR: begin
          count <= count + 1'b1;
          if (count + 1'b1 == len_q) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= RD;
            address <= src_q + count[AW-1:0] + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - bench for mem_copy_engine wired to mem_sync
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [8:0]  len;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic [7:0]  eng_addr;
  logic [15:0] eng_wd;
  logic        eng_wen;
  logic [15:0] rd;

  logic        sel;
  logic [7:0]  tb_addr;
  logic [15:0] tb_wd;
  logic        tb_wen;
  logic [7:0]  m_addr;
  logic [15:0] m_wd;
  logic        m_wen;

  assign m_addr = sel ? tb_addr : eng_addr;
  assign m_wd   = sel ? tb_wd   : eng_wd;
  assign m_wen  = sel ? tb_wen  : eng_wen;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .count(count), .address(eng_addr),
    .wd(eng_wd), .wen(eng_wen), .rd(rd)
  );

  mem_sync u_mem (
    .clk(clk), .address(m_addr), .wd(m_wd), .wen(m_wen), .rd(rd)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] model   [256];
  logic [15:0] mem_now [256];

  int         r_done_at, r_wens, r_busy_hi, r_dones, r_rst_at;
  logic       r_rst_wen, r_rst_busy;
  logic [8:0] r_rst_count;

  task automatic mem_wr(input logic [7:0] a, input logic [15:0] v);
    @(negedge clk);
    sel = 1'b1; tb_addr = a; tb_wd = v; tb_wen = 1'b1;
    @(negedge clk);
    tb_wen = 1'b0;
    model[a] = v;
  endtask

  task automatic snapshot();
    @(negedge clk);
    sel = 1'b1; tb_wen = 1'b0; tb_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      mem_now[i] = rd;
      tb_addr = 8'(i + 1);
    end
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int words);
    for (int i = 0; i < words; i++) model[8'(d + i)] = model[8'(s + i)];
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                          input int inj_at, input int rst_after_wens, input bit start_at_done);
    int n;
    r_done_at = -1; r_wens = 0; r_busy_hi = 0; r_dones = 0; r_rst_at = -1;
    r_rst_wen = 1'bx; r_rst_busy = 1'bx; r_rst_count = 'x;
    @(negedge clk);
    sel = 1'b0; tb_wen = 1'b0;
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n <= 1000; n++) begin
      if (r_rst_at > 0 && n == r_rst_at + 1) begin
        r_rst_wen = eng_wen; r_rst_busy = busy; r_rst_count = count;
        rst = 1'b0;
      end
      if (eng_wen) r_wens++;
      if (busy) r_busy_hi++;
      if (done) begin
        r_dones++;
        if (r_done_at < 0) r_done_at = n;
      end
      if (inj_at != 0 && n == inj_at) begin
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd0; len = 9'd9;
      end
      if (inj_at != 0 && n == inj_at + 1) start = 1'b0;
      if (start_at_done && done && n == r_done_at) begin
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'hF0; len = 9'd1;
      end
      if (start_at_done && r_done_at > 0 && n == r_done_at + 1) start = 1'b0;
      if (rst_after_wens > 0 && r_rst_at < 0 && r_wens == rst_after_wens) begin
        rst = 1'b1; r_rst_at = n;
      end
      if (r_done_at > 0 && n >= r_done_at + 4) break;
      if (r_rst_at > 0 && n >= r_rst_at + 8) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b1; tb_wen = 1'b0; tb_addr = '0; tb_wd = '0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(negedge clk);
    total++; if (eng_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", eng_wen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (count !== 9'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (eng_addr !== 8'd0 || eng_wd !== 16'd0) begin
      bad++; $display("FAIL reset_addr_wd: got %h/%h want 00/0000", eng_addr, eng_wd);
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem_wr(8'(i), 16'($urandom));
  endtask

  task automatic test_basic();
    int mm;
    for (int i = 0; i < 4; i++) mem_wr(8'(8'h10 + i), 16'(16'h00A0 + i));
    run_copy(8'h10, 8'h40, 9'd4, 0, 0, 1'b0);
    model_copy(8'h10, 8'h40, 4);
    total++; if (r_done_at !== 13) begin bad++; $display("FAIL basic_done_at: got %0d want 13", r_done_at); end
    total++; if (r_wens !== 4) begin bad++; $display("FAIL basic_wens: got %0d want 4", r_wens); end
    total++; if (r_busy_hi !== 12) begin bad++; $display("FAIL basic_busy: got %0d want 12", r_busy_hi); end
    total++; if (r_dones !== 1) begin bad++; $display("FAIL basic_dones: got %0d want 1", r_dones); end
    total++; if (count !== 9'd4) begin bad++; $display("FAIL basic_count: got %0d want 4", count); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL basic_mem: got %0d differing words want 0", mm); end
    total++; if (mem_now[8'h43] !== 16'h00A3) begin bad++; $display("FAIL basic_word43: got %h want 00a3", mem_now[8'h43]); end
  endtask

  task automatic test_len_zero();
    int mm;
    run_copy(8'h05, 8'h06, 9'd0, 0, 0, 1'b0);
    total++; if (r_done_at !== 1) begin bad++; $display("FAIL zero_done_at: got %0d want 1", r_done_at); end
    total++; if (r_wens !== 0) begin bad++; $display("FAIL zero_wens: got %0d want 0", r_wens); end
    total++; if (r_busy_hi !== 0) begin bad++; $display("FAIL zero_busy: got %0d want 0", r_busy_hi); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL zero_mem: got %0d differing words want 0", mm); end
  endtask

  task automatic test_wrap();
    int mm;
    mem_wr(8'hFE, 16'd1); mem_wr(8'hFF, 16'd2); mem_wr(8'h00, 16'd3); mem_wr(8'h01, 16'd4);
    run_copy(8'hFE, 8'h80, 9'd4, 0, 0, 1'b0);
    model_copy(8'hFE, 8'h80, 4);
    total++; if (r_done_at !== 13) begin bad++; $display("FAIL wrap_done_at: got %0d want 13", r_done_at); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL wrap_mem: got %0d differing words want 0", mm); end
    total++; if (mem_now[8'h82] !== 16'd3 || mem_now[8'h83] !== 16'd4) begin
      bad++; $display("FAIL wrap_words: got %h %h want 0003 0004", mem_now[8'h82], mem_now[8'h83]);
    end
  endtask

  task automatic test_overlap();
    int mm;
    for (int i = 0; i < 4; i++) mem_wr(8'(8'h20 + i), 16'(5 + i));
    run_copy(8'h20, 8'h21, 9'd3, 0, 0, 1'b0);
    model_copy(8'h20, 8'h21, 3);
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL overlap_mem: got %0d differing words want 0", mm); end
    total++; if (mem_now[8'h21] !== 16'd5 || mem_now[8'h22] !== 16'd5 || mem_now[8'h23] !== 16'd5) begin
      bad++; $display("FAIL overlap_words: got %h %h %h want 0005 0005 0005",
                      mem_now[8'h21], mem_now[8'h22], mem_now[8'h23]);
    end
  endtask

  task automatic test_ignored_start();
    int mm;
    run_copy(8'h30, 8'h60, 9'd6, 4, 0, 1'b0);
    model_copy(8'h30, 8'h60, 6);
    total++; if (r_dones !== 1) begin bad++; $display("FAIL ign_dones: got %0d want 1", r_dones); end
    total++; if (r_done_at !== 19) begin bad++; $display("FAIL ign_done_at: got %0d want 19", r_done_at); end
    total++; if (r_wens !== 6) begin bad++; $display("FAIL ign_wens: got %0d want 6", r_wens); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL ign_mem: got %0d differing words want 0", mm); end
  endtask

  task automatic test_start_at_done();
    run_copy(8'h70, 8'hA0, 9'd2, 0, 0, 1'b1);
    model_copy(8'h70, 8'hA0, 2);
    total++; if (r_busy_hi !== 6) begin bad++; $display("FAIL fin_start_busy: got %0d want 6", r_busy_hi); end
    total++; if (r_dones !== 1) begin bad++; $display("FAIL fin_start_dones: got %0d want 1", r_dones); end
    total++; if (count !== 9'd2) begin bad++; $display("FAIL fin_start_count_hold: got %0d want 2", count); end
  endtask

  task automatic test_reset_mid();
    int mm;
    run_copy(8'h50, 8'h90, 9'd5, 0, 2, 1'b0);
    model_copy(8'h50, 8'h90, 2);
    total++; if (r_rst_wen !== 1'b0) begin bad++; $display("FAIL rst_wen: got %b want 0", r_rst_wen); end
    total++; if (r_rst_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", r_rst_busy); end
    total++; if (r_rst_count !== 9'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", r_rst_count); end
    total++; if (r_dones !== 0) begin bad++; $display("FAIL rst_dones: got %0d want 0", r_dones); end
    total++; if (r_wens !== 2) begin bad++; $display("FAIL rst_wens: got %0d want 2", r_wens); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL rst_mem: got %0d differing words want 0", mm); end
  endtask

  task automatic test_random();
    int mm;
    logic [7:0] s, d;
    logic [8:0] l;
    for (int k = 0; k < 6; k++) begin
      s = 8'($urandom); d = 8'($urandom); l = 9'($urandom_range(24, 1));
      run_copy(s, d, l, 0, 0, 1'b0);
      model_copy(s, d, int'(l));
      total++; if (r_done_at !== 3 * int'(l) + 1) begin
        bad++; $display("FAIL rand_done_at[%0d]: got %0d want %0d", k, r_done_at, 3 * int'(l) + 1);
      end
      total++; if (count !== l) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", k, count, l); end
      snapshot();
      mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
      total++; if (mm != 0) begin bad++; $display("FAIL rand_mem[%0d]: got %0d differing words want 0", k, mm); end
    end
  endtask

  task automatic test_full();
    int mm;
    logic [7:0] s, d;
    s = 8'($urandom); d = 8'($urandom);
    run_copy(s, d, 9'd256, 0, 0, 1'b0);
    model_copy(s, d, 256);
    total++; if (r_done_at !== 769) begin bad++; $display("FAIL full_done_at: got %0d want 769", r_done_at); end
    total++; if (r_wens !== 256) begin bad++; $display("FAIL full_wens: got %0d want 256", r_wens); end
    total++; if (count !== 9'd256) begin bad++; $display("FAIL full_count: got %0d want 256", count); end
    snapshot();
    mm = 0; for (int i = 0; i < 256; i++) if (mem_now[i] !== model[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL full_mem: got %0d differing words want 0", mm); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_overlap();
    test_ignored_start();
    test_start_at_done();
    test_reset_mid();
    test_random();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator for the single-port synchronous memory interface: address 8 b, wd 16 b, wen, rd 16 b.
- On a start pulse it copies len consecutive 16-bit words from src_addr to dst_addr through that one port, one word at a time.
- Sits between control logic and the mem_sync instance; it is the only master of the memory port while busy.

Parameters:
- AW, 8, address width; memory depth 2**AW.
- DW, 16, data width.
- RD_LAT, 1, clock edges from the address being presented with wen=0 until rd holds that word (1 for mem_sync).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  AW  first source word address; captured on accepted start.
- dst_addr  in  AW  first destination word address; captured on accepted start.
- len  in  AW+1  word count, 0..2**AW; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- count  out  AW+1  words written so far in the current or last copy.
- address  out  AW  memory address.
- wd  out  DW  memory write data.
- wen  out  1  memory write enable.
- rd  in  DW  memory read data.

Behaviour:
- Memory-side outputs (address, wd, wen) and status outputs (busy, done, count) are all registered.
- Reset values: address=0, wd=0, wen=0, busy=0, done=0, count=0; FSM returns to IDLE.
- FSM states: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - start=1 and len!=0: capture src, dst and len; clear count; go to RD.
  - start=1 and len==0: go to FIN; no memory access.
- RD:
  - address=src+count (mod 2**AW), wen=0.
  - Go to WAIT.
- WAIT:
  - Stay RD_LAT cycles. rd is captured into the data register on the last WAIT cycle.
  - Go to WR.
- WR:
  - address=dst+count (mod 2**AW), wd=captured word, wen=1 for exactly one cycle.
  - count increments.
  - If count+1==len go to FIN, else go to RD.
- FIN:
  - done=1 for one cycle; busy drops in the same cycle; wen=0.
  - Go to IDLE.
- Cost: 2+RD_LAT cycles per word, so 3 with the default RD_LAT.
- busy is 1 in RD, WAIT and WR, and 0 in IDLE and FIN.
- wen is 1 only in WR and is never asserted in any other state.
- Address wrap: src+count and dst+count wrap modulo 2**AW. For example, src=FE with len=4 reads FE, FF, 00, 01.
- len=2**AW (256) copies the whole memory.
- Overlap: the copy is strictly forward, word by word.
  - dst<src: correct memmove result.
  - dst>src and the regions overlap: source words are overwritten before they are read, so data replicates. This is the defined behaviour, not an error.
  - dst==src: rewrites each word unchanged.
- start while busy or in FIN is ignored, with no queuing.
- A start in the same cycle that FIN pulses done is ignored; the new request must arrive while in IDLE.
- rst mid-copy aborts immediately: wen=0 from the next edge, the partial copy is left in memory, and done is not pulsed.
- count holds its final value in IDLE until the next accepted start.

Decomposition:
- Shared package mem_pkg holds:
  - localparams MEM_AW=8, MEM_DW=16, MEM_RD_LAT=1;
  - typedef mem_addr_t = logic [MEM_AW-1:0];
  - typedef mem_data_t = logic [MEM_DW-1:0];
  - enum copy_state_t {IDLE, RD, WAIT, WR, FIN}.
- Single module; no sub-module is needed.
- The bench instantiates mem_copy_engine wired to mem_sync and preloads memory through the same port before start (engine idle, memory driven by bench via a mux).

Test Plan:
- Preload mem[10..13]=A0,A1,A2,A3; start src=10 dst=40 len=4 -> mem[40..43]=A0..A3; exactly 4 wen pulses; done 12 cycles (+1 FIN) after start; count=4.
- len=0 at src=5 dst=6 -> done pulses the cycle after the start edge; wen never 1; busy never 1; memory unchanged.
- Wrap: mem[FE,FF,00,01]=1,2,3,4; src=FE dst=80 len=4 -> mem[80..83]=1,2,3,4.
- Overlap: mem[20..23]=5,6,7,8; src=20 dst=21 len=3 -> mem[21..23]=5,5,5.
- Second start pulsed mid-copy with src=0 dst=0 len=9 -> ignored; first copy result unchanged; single done.
- rst asserted after 2nd wen of a len=5 copy -> wen=0 from next edge; busy=0, count=0; only 2 destination words changed; no done.
